// File: rtl/dmem_resp_pkg.sv
// Shared constants and FSM encoding for the handshaked data-memory responder.
package dmem_resp_pkg;

  localparam int unsigned DMEM_XLEN = 64;
  localparam logic [31:0] DMEM_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_resp_array.sv
// Word-wide storage with per-byte write enables and combinational read.
// Kept separate so a vendor RAM macro can replace it.
module dmem_resp_array #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IW    = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IW-1:0]     i_idx,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN/8-1:0] i_wstrb,
  output logic [XLEN-1:0]   o_rdata
);

  localparam int unsigned SW = XLEN / 8;

  logic [XLEN-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < SW; i++) begin
        if (i_wstrb[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_resp.sv
// Memory-side responder for the LS request bus: one outstanding request,
// programmable wait latency, range-checked word access with byte strobes.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned    XLEN  = DMEM_XLEN,
  parameter int unsigned    AW    = 32,
  parameter int unsigned    DEPTH = 1024,
  parameter int unsigned    LAT   = 2,
  parameter logic [AW-1:0]  BASE  = AW'(DMEM_BASE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [AW-1:0]     req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned SW = XLEN / 8;
  localparam int unsigned IW = $clog2(DEPTH);

  dmem_state_e     r_state;
  logic [3:0]      r_cnt;
  logic            r_wen;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [SW-1:0]   r_wstrb;
  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_rdata;
  logic            r_rsp_err;

  logic            w_accept;
  logic            w_commit;
  logic            w_wen;
  logic [AW-1:0]   w_addr;
  logic [XLEN-1:0] w_wdata;
  logic [SW-1:0]   w_wstrb;
  logic [AW-1:0]   w_off;
  logic [AW-1:0]   w_word;
  logic            w_in_range;
  logic [IW-1:0]   w_idx;
  logic            w_we;
  logic [XLEN-1:0] w_rdata;

  assign req_ready = (r_state == DMEM_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_commit  = (w_accept && (LAT == 0)) || ((r_state == DMEM_WAIT) && (r_cnt == 4'd1));

  // With zero latency the commit happens on the accept edge, before the latch holds anything.
  assign w_wen   = req_ready ? req_wen   : r_wen;
  assign w_addr  = req_ready ? req_addr  : r_addr;
  assign w_wdata = req_ready ? req_wdata : r_wdata;
  assign w_wstrb = req_ready ? req_wstrb : r_wstrb;

  assign w_off      = w_addr - BASE;
  assign w_word     = w_off >> 3;
  assign w_in_range = (w_addr >= BASE) && (w_word < AW'(DEPTH));
  assign w_idx      = w_word[IW-1:0];
  assign w_we       = w_commit && w_wen && w_in_range;

  dmem_resp_array #(
    .XLEN (XLEN),
    .DEPTH(DEPTH),
    .IW   (IW)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_idx  (w_idx),
    .i_wdata(w_wdata),
    .i_wstrb(w_wstrb),
    .o_rdata(w_rdata)
  );

  // Handshake FSM, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= DMEM_IDLE;
      r_cnt       <= 4'd0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        DMEM_IDLE: begin
          if (w_accept) begin
            r_wen   <= req_wen;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
            if (LAT == 0) begin
              r_state <= DMEM_RESP;
            end else begin
              r_state <= DMEM_WAIT;
              r_cnt   <= 4'(LAT);
            end
          end
        end
        DMEM_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= DMEM_RESP;
        end
        DMEM_RESP: begin
          if (rsp_ready) begin
            r_state     <= DMEM_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: r_state <= DMEM_IDLE;
      endcase
      if (w_commit) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= (w_wen || !w_in_range) ? '0 : w_rdata;
        r_rsp_err   <= !w_in_range;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed vector table, multi-cycle corner
// sequences on LAT=2 and LAT=0 instances, then random traffic against a word model.
module tb_dmem_resp;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 1024;

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rd;
    bit          err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_ready;

  logic        rr2, rv2, re2, rr0, rv0, re0;
  logic [63:0] rd2, rd0;
  logic        m_ready, m_valid, m_err;
  logic [63:0] m_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [63:0] mdl [int unsigned];

  always #5 clk = ~clk;

  dmem_resp #(.LAT(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(rr2), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rv2), .rsp_ready(rsp_ready & ~sel), .rsp_rdata(rd2), .rsp_err(re2)
  );

  dmem_resp #(.LAT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(rr0), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rv0), .rsp_ready(rsp_ready & sel), .rsp_rdata(rd0), .rsp_err(re0)
  );

  assign m_ready = sel ? rr0 : rr2;
  assign m_valid = sel ? rv0 : rv2;
  assign m_rdata = sel ? rd0 : rd2;
  assign m_err   = sel ? re0 : re2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Reference: range rule and byte merge computed directly from addresses.
  function automatic void model_txn(input vec_t v, output logic [63:0] rd, output bit err);
    int unsigned idx;
    logic [63:0] w;
    if (v.addr < BASE || ((v.addr - BASE) / 8) >= DEPTH) begin
      rd  = '0;
      err = 1'b1;
    end else begin
      idx = (v.addr - BASE) / 8;
      err = 1'b0;
      if (v.wen) begin
        w = mdl.exists(idx) ? mdl[idx] : 64'h0;
        for (int i = 0; i < 8; i++) if (v.wstrb[i]) w[8*i +: 8] = v.wdata[8*i +: 8];
        mdl[idx] = w;
        rd = '0;
      end else begin
        rd = mdl[idx];
      end
    end
  endfunction

  // One full request/response transaction with latency, data and backpressure checks.
  task automatic do_txn(input bit s, input vec_t v, input int hold, input string nm);
    int n;
    int lat;
    int exp_lat;
    bit seen;
    logic [63:0] held;
    @(negedge clk);
    sel       = s;
    req_valid = 1'b1;
    req_wen   = v.wen;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_wstrb = v.wstrb;
    n = 0;
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk({nm, " accept timeout"}, 64'(m_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    exp_lat = s ? 1 : 3;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (m_valid) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    if (!seen) return;
    chk({nm, " rdata"}, m_rdata, v.rd);
    chk({nm, " err"}, 64'(m_err), 64'(v.err));
    held = m_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, " stall valid/ready"}, {62'd0, m_valid, m_ready}, 64'd2);
      chk({nm, " stall rdata"}, m_rdata, held);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, " post-handshake"}, {m_rdata[61:0], m_valid, m_ready} | 64'(m_err) << 63,
        64'd1);
  endtask

  vec_t vt [15];
  vec_t rv;
  logic [63:0] e_rd;
  bit          e_err;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 32'h8000_0010, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
    vt[1]  = '{1'b0, 32'h8000_0010, 64'h0, 8'h00, 64'h1122334455667788, 1'b0};
    vt[2]  = '{1'b1, 32'h8000_0010, 64'hAAAAAAAAAAAAAAAA, 8'h81, 64'h0, 1'b0};
    vt[3]  = '{1'b0, 32'h8000_0010, 64'h0, 8'h00, 64'hAA223344556677AA, 1'b0};
    vt[4]  = '{1'b1, 32'h8000_0000, 64'h5555555555555555, 8'hFF, 64'h0, 1'b0};
    vt[5]  = '{1'b1, 32'h8000_1FF8, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0};
    vt[6]  = '{1'b0, 32'h7FFF_FFF8, 64'h0, 8'h00, 64'h0, 1'b1};
    vt[7]  = '{1'b1, 32'h8000_2000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1};
    vt[8]  = '{1'b0, 32'h8000_1FF8, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0};
    vt[9]  = '{1'b0, 32'h8000_0000, 64'h0, 8'h00, 64'h5555555555555555, 1'b0};
    vt[10] = '{1'b1, 32'h8000_0010, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0, 1'b0};
    vt[11] = '{1'b0, 32'h8000_0017, 64'h0, 8'h00, 64'hAA223344556677AA, 1'b0};
    vt[12] = '{1'b0, 32'hFFFF_FFF8, 64'h0, 8'h00, 64'h0, 1'b1};
    vt[13] = '{1'b1, 32'h7FFF_FFF8, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1};
    vt[14] = '{1'b0, 32'h8000_1FF8, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0};

    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset L2 ready", 64'(rr2), 64'd1);
    chk("reset L2 valid/err", {62'd0, rv2, re2}, 64'd0);
    chk("reset L2 rdata", rd2, 64'd0);
    chk("reset L0 ready", 64'(rr0), 64'd1);
    chk("reset L0 valid/err", {62'd0, rv0, re0}, 64'd0);
    chk("reset L0 rdata", rd0, 64'd0);

    for (int i = 0; i < 15; i++) do_txn(1'b0, vt[i], 0, $sformatf("vec%0d", i));

    do_txn(1'b0, vt[3], 5, "backpressure");

    // Reset while LAT=2 request waits: the store must never land.
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE;
    req_wdata = 64'hDEAD; req_wstrb = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midwait no response", {62'd0, rv2, rr2}, 64'd1);
    end
    do_txn(1'b0, vt[9], 0, "midwait old value");

    // LAT=0: commit happens on accept, so reset in RESP keeps the write.
    do_txn(1'b1, '{1'b1, BASE, 64'h1111, 8'hFF, 64'h0, 1'b0}, 0, "lat0 store");
    do_txn(1'b1, '{1'b0, BASE, 64'h0, 8'h00, 64'h1111, 1'b0}, 0, "lat0 load");
    @(negedge clk);
    sel = 1'b1; req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE;
    req_wdata = 64'hDEAD; req_wstrb = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("lat0 one-cycle response", {62'd0, rv0, rr0}, 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lat0 reset in resp", {62'd0, rv0, rr0}, 64'd1);
    do_txn(1'b1, '{1'b0, BASE, 64'h0, 8'h00, 64'hDEAD, 1'b0}, 0, "lat0 committed persists");

    // Random traffic on the LAT=2 instance over a seeded pool of words.
    for (int i = 0; i < 8; i++) begin
      rv = '{1'b1, BASE + 32'(8 * (100 + i)), {$urandom, $urandom}, 8'hFF, 64'h0, 1'b0};
      model_txn(rv, e_rd, e_err);
      rv.rd = e_rd; rv.err = e_err;
      do_txn(1'b0, rv, 0, $sformatf("seed%0d", i));
    end
    for (int i = 0; i < 40; i++) begin
      rv.wen   = $urandom_range(0, 1) == 1;
      rv.wdata = {$urandom, $urandom};
      rv.wstrb = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       rv.addr = 32'($urandom_range(0, 32'h7FFF_FFFF));
        1:       rv.addr = BASE + 32'h2000 + 32'($urandom_range(0, 32'h7FFF_DFFF));
        default: rv.addr = BASE + 32'(8 * (100 + $urandom_range(0, 7))) + 32'($urandom_range(0, 7));
      endcase
      model_txn(rv, e_rd, e_err);
      rv.rd = e_rd; rv.err = e_err;
      do_txn(1'b0, rv, $urandom_range(0, 2), $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
